ps2_scancode_tx: RTL
====================

Name: ps2_scancode_tx

Overview:
Device-side PS/2 keyboard emulator. It converts the two sensor alarm flags into keyboard scan codes and serialises them on PS/2 clock/data lines. The codes are the ones the receiving decoder already maps: 8'h2C = Temp only, 8'h33 = Humo only, 8'h1C = both. It is used as the stimulus source and loop-back partner for the scan-code receive path on the board.

Parameters:
CLK_DIV, 2500, system clock cycles per PS/2 half-bit (each clock phase); 50 MHz gives 10 kHz PS/2 clock
IDLE_GAP, 5000, system clock cycles with both lines high after each byte before the next byte or return to idle

Ports:
CLK_clk_i  input  1  system clock; all logic on rising edge
RST_rst_i  input  1  synchronous reset, active-low (0 = reset)
Sensor_Temp_i  input  1  temperature alarm flag, level
Sensor_Humo_i  input  1  smoke alarm flag, level
ps2_clk_o  output  1  PS/2 clock line, idles high
ps2_data_o  output  1  PS/2 data line, idles high
busy_o  output  1  high while a byte sequence (including gaps) is in progress
sent_o  output  1  one-cycle pulse when a byte's stop bit completes
code_o  output  8  last byte fully transmitted; updated with sent_o

Behaviour:
- Reset (RST_rst_i=0 at a rising edge):
  - ps2_clk_o=1, ps2_data_o=1, busy_o=0, sent_o=0, code_o=8'h00.
  - last_code=NONE; state=IDLE; all counters cleared.
  - Takes effect on the next edge even mid-frame; the partial frame is abandoned and no sent_o is generated.
- Code mapping of {Sensor_Temp_i, Sensor_Humo_i}: 10→2C, 01→33, 11→1C, 00→NONE.
- IDLE: each cycle compute desired code. If desired == last_code, stay in IDLE. Otherwise latch a byte sequence, set busy_o the next cycle, and set last_code := desired:
  - last_code NONE, desired X: send X.
  - last_code Y, desired NONE: send F0, Y.
  - last_code Y, desired X (X≠Y): send F0, Y, X.
- Inputs are not sampled while busy. On return to IDLE they are re-evaluated, so a change made mid-sequence is sent afterwards. A pulse that goes and comes back while busy produces nothing.
- Frame per byte: 11 bits in order:
  - start bit 0
  - data[0]..data[7], LSB first
  - odd parity = ~^data
  - stop bit 1
- Bit timing:
  - ps2_data_o changes on the first cycle of a bit while ps2_clk_o is high.
  - ps2_clk_o stays high CLK_DIV cycles, then low CLK_DIV cycles.
  - A bit is 2*CLK_DIV cycles; a frame is 22*CLK_DIV cycles.
  - Data is stable throughout the low phase, so the host samples on the falling edge.
- States: IDLE → START → DATA (8 bits, 3-bit index) → PARITY → STOP → GAP → (next byte: START | sequence done: IDLE).
- At the last cycle of the STOP low phase:
  - sent_o=1 for one cycle.
  - code_o := byte.
  - ps2_clk_o returns high.
- GAP: both lines high for IDLE_GAP cycles. busy_o stays 1 through the final GAP and drops on entry to IDLE.
- Outputs are registered and glitch-free. The half-bit counter is wide enough for CLK_DIV; the gap counter is wide enough for IDLE_GAP.

Test Plan:
All scenarios use CLK_DIV=4, IDLE_GAP=8, so one frame = 88 cycles.

1. Hold RST_rst_i=0 for 3 cycles with inputs 11 → ps2_clk_o=1, ps2_data_o=1, busy_o=0, code_o=00, no clock activity. After release, a 1C frame starts.
2. Temp=1, Humo=0 → one frame. Data bits sampled at ps2_clk_o falling edges: 0, 0,0,1,1,0,1,0,0, parity 0, stop 1. Then sent_o pulses once with code_o=2C, 8 gap cycles, and busy_o falls.
3. After step 2, set inputs 00 → two frames: F0 (parity 1), then 2C (parity 0). sent_o pulses twice with code_o F0 then 2C; then idle with last_code NONE.
4. Step inputs 10→11 after 10 has finished → three frames F0, 2C, 1C (1C parity 0). Then switch to 01 → F0, 1C, 33 (33 has 4 ones, parity 1).
5. While sending 2C, pulse Humo=1 for 20 cycles and release → only the 2C frame is sent and no further frames. Holding Humo=1 through the end instead yields F0, 2C, 1C after return to IDLE.
6. Assert reset at bit 5 of a frame → both lines high on the next cycle, busy_o=0, no sent_o, code_o=00. After release with the same inputs, the full frame is resent from the start bit.

Source files
------------

// File: rtl/ps2_scancode_tx.sv
// Device-side PS/2 keyboard emulator: turns the Temp/Humo alarm flags into
// make/break scan-code sequences and shifts them out as 11-bit PS/2 frames.
module ps2_scancode_tx #(
    parameter int CLK_DIV  = 2500,
    parameter int IDLE_GAP = 5000
) (
    input  logic       CLK_clk_i,
    input  logic       RST_rst_i,
    input  logic       Sensor_Temp_i,
    input  logic       Sensor_Humo_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy_o,
    output logic       sent_o,
    output logic [7:0] code_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    // 8'h00 never appears as a real code, so it doubles as "no key held".
    localparam logic [7:0] CODE_NONE  = 8'h00;
    localparam logic [7:0] CODE_TEMP  = 8'h2C;
    localparam logic [7:0] CODE_HUMO  = 8'h33;
    localparam logic [7:0] CODE_BOTH  = 8'h1C;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             low_phase_q, low_phase_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]       seq0_q, seq0_d;
    logic [7:0]       seq1_q, seq1_d;
    logic [7:0]       seq2_q, seq2_d;
    logic [1:0]       seq_len_q, seq_len_d;
    logic [1:0]       seq_idx_q, seq_idx_d;
    logic [7:0]       last_code_q, last_code_d;
    logic             clk_q, clk_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic [7:0]       code_q, code_d;

    logic [7:0]       desired_code;
    logic [7:0]       cur_byte;
    logic             half_end;
    logic [2:0]       next_bit_idx;
    logic [1:0]       next_seq_idx;

    always_comb begin
        case ({Sensor_Temp_i, Sensor_Humo_i})
            2'b10:   desired_code = CODE_TEMP;
            2'b01:   desired_code = CODE_HUMO;
            2'b11:   desired_code = CODE_BOTH;
            default: desired_code = CODE_NONE;
        endcase
    end

    always_comb begin
        case (seq_idx_q)
            2'd0:    cur_byte = seq0_q;
            2'd1:    cur_byte = seq1_q;
            default: cur_byte = seq2_q;
        endcase
    end

    assign half_end     = (div_cnt_q == DIV_LAST);
    assign next_bit_idx = bit_idx_q + 3'd1;
    assign next_seq_idx = seq_idx_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        low_phase_d = low_phase_q;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;
        seq0_d      = seq0_q;
        seq1_d      = seq1_q;
        seq2_d      = seq2_q;
        seq_len_d   = seq_len_q;
        seq_idx_d   = seq_idx_q;
        last_code_d = last_code_q;
        clk_d       = clk_q;
        data_d      = data_q;
        busy_d      = busy_q;
        sent_d      = 1'b0;
        code_d      = code_q;

        case (state_q)
            ST_IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                busy_d = 1'b0;
                if (desired_code != last_code_q) begin
                    state_d     = ST_START;
                    busy_d      = 1'b1;
                    data_d      = 1'b0;
                    div_cnt_d   = '0;
                    low_phase_d = 1'b0;
                    seq_idx_d   = 2'd0;
                    last_code_d = desired_code;
                    if (last_code_q == CODE_NONE) begin
                        seq0_d    = desired_code;
                        seq_len_d = 2'd1;
                    end else if (desired_code == CODE_NONE) begin
                        seq0_d    = CODE_BREAK;
                        seq1_d    = last_code_q;
                        seq_len_d = 2'd2;
                    end else begin
                        seq0_d    = CODE_BREAK;
                        seq1_d    = last_code_q;
                        seq2_d    = desired_code;
                        seq_len_d = 2'd3;
                    end
                end
            end

            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (!half_end) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!low_phase_q) begin
                        low_phase_d = 1'b1;
                        clk_d       = 1'b0;
                    end else begin
                        // End of a bit: clock back high and present the next bit together.
                        low_phase_d = 1'b0;
                        clk_d       = 1'b1;
                        case (state_q)
                            ST_START: begin
                                state_d   = ST_DATA;
                                bit_idx_d = 3'd0;
                                data_d    = cur_byte[0];
                            end
                            ST_DATA: begin
                                if (bit_idx_q == 3'd7) begin
                                    state_d = ST_PARITY;
                                    data_d  = ~^cur_byte;
                                end else begin
                                    bit_idx_d = next_bit_idx;
                                    data_d    = cur_byte[next_bit_idx];
                                end
                            end
                            ST_PARITY: begin
                                state_d = ST_STOP;
                                data_d  = 1'b1;
                            end
                            default: begin
                                state_d   = ST_GAP;
                                data_d    = 1'b1;
                                gap_cnt_d = '0;
                                sent_d    = 1'b1;
                                code_d    = cur_byte;
                            end
                        endcase
                    end
                end
            end

            ST_GAP: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (next_seq_idx < seq_len_q) begin
                        state_d     = ST_START;
                        seq_idx_d   = next_seq_idx;
                        data_d      = 1'b0;
                        div_cnt_d   = '0;
                        low_phase_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                clk_d   = 1'b1;
                data_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_clk_i) begin
        if (!RST_rst_i) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            low_phase_q <= 1'b0;
            bit_idx_q   <= 3'd0;
            gap_cnt_q   <= '0;
            seq0_q      <= 8'h00;
            seq1_q      <= 8'h00;
            seq2_q      <= 8'h00;
            seq_len_q   <= 2'd0;
            seq_idx_q   <= 2'd0;
            last_code_q <= CODE_NONE;
            clk_q       <= 1'b1;
            data_q      <= 1'b1;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            code_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            low_phase_q <= low_phase_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            seq0_q      <= seq0_d;
            seq1_q      <= seq1_d;
            seq2_q      <= seq2_d;
            seq_len_q   <= seq_len_d;
            seq_idx_q   <= seq_idx_d;
            last_code_q <= last_code_d;
            clk_q       <= clk_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            code_q      <= code_d;
        end
    end

    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = data_q;
    assign busy_o     = busy_q;
    assign sent_o     = sent_q;
    assign code_o     = code_q;

endmodule
